// File: rtl/add_nbit_pipe.sv
// add_nbit_pipe: pipelined N-bit adder/subtractor.
// The carry chain is cut into STAGES slices of W = N/STAGES bits with a register after each slice.
// Each operation carries its own effective operands, carry and valid bit down the pipe.
// The result appears exactly STAGES accepting edges after the operation is taken.
// N must be a non-zero multiple of STAGES, and STAGES must be at least 1.
module add_nbit_pipe #(
   parameter int N      = 8,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         valid_in,
   input  logic         stall_in,
   input  logic         sub_in,
   input  logic [N-1:0] a_in,
   input  logic [N-1:0] b_in,
   input  logic         carry_in,
   output logic         valid_out,
   output logic [N-1:0] sum_out,
   output logic         carry_out,
   output logic         overflow_out
);

   localparam int W = N / STAGES;

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         // LO is the first bit of this slice; HI is the count of sum bits settled after it
         localparam int LO = k * W;
         localparam int HI = (k + 1) * W;

         logic [N-LO-1:0] a_src_s;   // operand A bits [N-1:LO] entering this stage
         logic [N-LO-1:0] b_src_s;   // effective B bits [N-1:LO] entering this stage
         logic            c_src_s;   // carry into this slice
         logic            v_src_s;   // valid bit entering this stage
         logic [W:0]      slice_s;   // slice sum including its carry out
         logic [HI-1:0]   sum_d;
         logic [HI-1:0]   sum_q;
         logic            c_d;
         logic            c_q;
         logic            v_d;
         logic            v_q;

         if (k == 0) begin : g_src
            // Form effective operands at the pipe entry; a bubble presents all-zero data
            always_comb begin
               if (valid_in == 1'b1) begin
                  a_src_s = a_in;
                  b_src_s = sub_in ? ~b_in : b_in;
                  c_src_s = sub_in ? 1'b1 : carry_in;
               end else begin
                  a_src_s = {N{1'b0}};
                  b_src_s = {N{1'b0}};
                  c_src_s = 1'b0;
               end
               v_src_s = valid_in;
            end

            // First slice starts the settled sum
            always_comb begin
               sum_d = slice_s[W-1:0];
            end
         end else begin : g_src
            // Take unprocessed operand bits, carry and valid from the previous stage
            always_comb begin
               a_src_s = g_stage[k-1].g_fwd.a_q;
               b_src_s = g_stage[k-1].g_fwd.b_q;
               c_src_s = g_stage[k-1].c_q;
               v_src_s = g_stage[k-1].v_q;
            end

            // Append this slice above the sum bits settled in earlier stages
            always_comb begin
               sum_d = {slice_s[W-1:0], g_stage[k-1].sum_q};
            end
         end

         // Add one W-bit slice with the incoming carry
         always_comb begin
            slice_s = {1'b0, a_src_s[W-1:0]} + {1'b0, b_src_s[W-1:0]} + {{W{1'b0}}, c_src_s};
            c_d     = slice_s[W];
            v_d     = v_src_s;
         end

         // Stage register: reset clears, stall holds, otherwise load the next state
         always_ff @(posedge clk) begin
            if (rst) begin
               sum_q <= {HI{1'b0}};
               c_q   <= 1'b0;
               v_q   <= 1'b0;
            end else if (!stall_in) begin
               sum_q <= sum_d;
               c_q   <= c_d;
               v_q   <= v_d;
            end else begin
               sum_q <= sum_q;
               c_q   <= c_q;
               v_q   <= v_q;
            end
         end

         if (k < STAGES - 1) begin : g_fwd
            logic [N-HI-1:0] a_d;
            logic [N-HI-1:0] a_q;
            logic [N-HI-1:0] b_d;
            logic [N-HI-1:0] b_q;

            // Pass the still-unprocessed upper operand bits to the next stage
            always_comb begin
               a_d = a_src_s[N-LO-1:W];
               b_d = b_src_s[N-LO-1:W];
            end

            // Operand delay register kept in step with the stage register
            always_ff @(posedge clk) begin
               if (rst) begin
                  a_q <= {(N-HI){1'b0}};
                  b_q <= {(N-HI){1'b0}};
               end else if (!stall_in) begin
                  a_q <= a_d;
                  b_q <= b_d;
               end else begin
                  a_q <= a_q;
                  b_q <= b_q;
               end
            end
         end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            // Signed overflow: operand signs agree but the result sign differs
            always_comb begin
               ovf_d = (a_src_s[N-LO-1] == b_src_s[N-LO-1]) && (sum_d[N-1] != a_src_s[N-LO-1]);
            end

            // Overflow register sits beside the final stage register
            always_ff @(posedge clk) begin
               if (rst) begin
                  ovf_q <= 1'b0;
               end else if (!stall_in) begin
                  ovf_q <= ovf_d;
               end else begin
                  ovf_q <= ovf_q;
               end
            end
         end
      end
   endgenerate

   assign valid_out    = g_stage[STAGES-1].v_q;
   assign sum_out      = g_stage[STAGES-1].sum_q;
   assign carry_out    = g_stage[STAGES-1].c_q;
   assign overflow_out = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_add_nbit_pipe.sv
// tb_add_nbit_pipe: directed checks of add_nbit_pipe at N=8 with STAGES 2/1/4/8 and N=32 with STAGES=4.
module tb_add_nbit_pipe;

   typedef struct packed {
      logic [7:0]  a;
      logic [7:0]  b;
      logic        cin;
      logic        sub;
      logic [10:0] exp;   // {valid, carry, overflow, sum}
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       valid_in;
   logic       stall_in;
   logic       sub_in;
   logic       carry_in;
   logic [7:0] a_in;
   logic [7:0] b_in;

   // index 0: STAGES=2, 1: STAGES=1, 2: STAGES=4, 3: STAGES=8
   logic       vo [4];
   logic       co [4];
   logic       ov [4];
   logic [7:0] so [4];
   int         lat [4];

   logic        w_valid;
   logic        w_sub;
   logic        w_cin;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic        w_vo;
   logic        w_co;
   logic        w_ov;
   logic [31:0] w_so;

   int n_checks = 0;
   int n_fail   = 0;

   add_nbit_pipe #(.N(8), .STAGES(2)) u_s2 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .sub_in(sub_in),
      .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
      .valid_out(vo[0]), .sum_out(so[0]), .carry_out(co[0]), .overflow_out(ov[0]));

   add_nbit_pipe #(.N(8), .STAGES(1)) u_s1 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .sub_in(sub_in),
      .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
      .valid_out(vo[1]), .sum_out(so[1]), .carry_out(co[1]), .overflow_out(ov[1]));

   add_nbit_pipe #(.N(8), .STAGES(4)) u_s4 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .sub_in(sub_in),
      .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
      .valid_out(vo[2]), .sum_out(so[2]), .carry_out(co[2]), .overflow_out(ov[2]));

   add_nbit_pipe #(.N(8), .STAGES(8)) u_s8 (
      .clk(clk), .rst(rst), .valid_in(valid_in), .stall_in(stall_in), .sub_in(sub_in),
      .a_in(a_in), .b_in(b_in), .carry_in(carry_in),
      .valid_out(vo[3]), .sum_out(so[3]), .carry_out(co[3]), .overflow_out(ov[3]));

   add_nbit_pipe #(.N(32), .STAGES(4)) u_w32 (
      .clk(clk), .rst(rst), .valid_in(w_valid), .stall_in(stall_in), .sub_in(w_sub),
      .a_in(w_a), .b_in(w_b), .carry_in(w_cin),
      .valid_out(w_vo), .sum_out(w_so), .carry_out(w_co), .overflow_out(w_ov));

   // Reference arithmetic for an n-bit operation; returns {overflow, carry, sum[31:0]}
   function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin, input logic sub, input int n);
      logic [32:0] mask;
      logic [32:0] effb;
      logic [32:0] tot;
      logic        ovf;
      mask = (33'd1 << n) - 33'd1;
      effb = {1'b0, (sub ? ~b : b)} & mask;
      tot  = {1'b0, a} + effb + {32'd0, (sub ? 1'b1 : cin)};
      ovf  = (a[n-1] == effb[n-1]) && (tot[n-1] != a[n-1]);
      return {ovf, tot[n], tot[31:0] & mask[31:0]};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      valid_in = 1'b0;
      stall_in = 1'b0;
      for (int i = 0; i < 10; i++) step();
   endtask

   task automatic test_reset();
      logic [10:0] got;
      rst = 1'b1; valid_in = 1'b0; stall_in = 1'b0; sub_in = 1'b0; carry_in = 1'b0;
      a_in = 8'd0; b_in = 8'd0;
      w_valid = 1'b0; w_sub = 1'b0; w_cin = 1'b0; w_a = 32'd0; w_b = 32'd0;
      for (int i = 0; i < 3; i++) step();
      for (int i = 0; i < 4; i++) begin
         got = {vo[i], co[i], ov[i], so[i]};
         n_checks++;
         if (got !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_outputs lat%0d: got %h expected %h", lat[i], got, 11'd0);
         end
      end
      n_checks++;
      if (w_vo !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_wide_valid: got %b expected 0", w_vo);
      end
      rst = 1'b0;
   endtask

   task automatic test_first_op();
      logic [10:0] got;
      valid_in = 1'b1; a_in = 8'd3; b_in = 8'd2; sub_in = 1'b0; carry_in = 1'b0;
      step();
      valid_in = 1'b0;
      got = {vo[0], co[0], ov[0], so[0]};
      n_checks++;
      if (got !== 11'd0) begin
         n_fail++;
         $display("FAIL first_op_early: got %h expected %h", got, 11'd0);
      end
      step();
      got = {vo[0], co[0], ov[0], so[0]};
      n_checks++;
      if (got !== {1'b1, 1'b0, 1'b0, 8'd5}) begin
         n_fail++;
         $display("FAIL first_op_result: got %h expected %h", got, {1'b1, 1'b0, 1'b0, 8'd5});
      end
      step();
      n_checks++;
      if (vo[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL first_op_single: got valid %b expected 0", vo[0]);
      end
   endtask

   task automatic test_boundary();
      vec_t        v [3];
      logic [10:0] got;
      v[0] = '{8'd255, 8'd255, 1'b0, 1'b0, {1'b1, 1'b1, 1'b0, 8'd254}};
      v[1] = '{8'd255, 8'd0,   1'b1, 1'b0, {1'b1, 1'b1, 1'b0, 8'd0}};
      v[2] = '{8'd127, 8'd1,   1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 8'd128}};
      for (int i = 0; i < 3; i++) begin
         valid_in = 1'b1; a_in = v[i].a; b_in = v[i].b; carry_in = v[i].cin; sub_in = v[i].sub;
         step();
         valid_in = 1'b0;
         step();
         got = {vo[0], co[0], ov[0], so[0]};
         n_checks++;
         if (got !== v[i].exp) begin
            n_fail++;
            $display("FAIL boundary_%0d: got %h expected %h", i, got, v[i].exp);
         end
      end
   endtask

   task automatic test_subtract();
      vec_t        v [4];
      logic [10:0] got;
      v[0] = '{8'd5,   8'd7, 1'b0, 1'b1, {1'b1, 1'b0, 1'b0, 8'd254}};
      v[1] = '{8'd128, 8'd1, 1'b0, 1'b1, {1'b1, 1'b1, 1'b1, 8'd127}};
      v[2] = '{8'd5,   8'd7, 1'b1, 1'b1, {1'b1, 1'b0, 1'b0, 8'd254}};
      v[3] = '{8'd0,   8'd0, 1'b0, 1'b1, {1'b1, 1'b1, 1'b0, 8'd0}};
      for (int i = 0; i < 4; i++) begin
         valid_in = 1'b1; a_in = v[i].a; b_in = v[i].b; carry_in = v[i].cin; sub_in = v[i].sub;
         step();
         valid_in = 1'b0;
         step();
         got = {vo[0], co[0], ov[0], so[0]};
         n_checks++;
         if (got !== v[i].exp) begin
            n_fail++;
            $display("FAIL subtract_%0d: got %h expected %h", i, got, v[i].exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  sa [6];
      logic [7:0]  sb [6];
      logic        sc [6];
      logic        ss [6];
      logic [33:0] m;
      logic [10:0] got;
      logic [10:0] exp;
      int          idx;
      sa = '{8'd10, 8'd100, 8'd200, 8'd3,   8'd64, 8'd0};
      sb = '{8'd20, 8'd50,  8'd100, 8'd250, 8'd64, 8'd1};
      sc = '{1'b0,  1'b0,   1'b1,   1'b1,   1'b0,  1'b0};
      ss = '{1'b0,  1'b1,   1'b0,   1'b1,   1'b0,  1'b1};
      flush();
      for (int j = 0; j < 14; j++) begin
         if (j < 6) begin
            valid_in = 1'b1; a_in = sa[j]; b_in = sb[j]; carry_in = sc[j]; sub_in = ss[j];
         end else begin
            valid_in = 1'b0;
         end
         step();
         for (int i = 0; i < 4; i++) begin
            idx = j - lat[i] + 1;
            got = {vo[i], co[i], ov[i], so[i]};
            n_checks++;
            if (idx >= 0 && idx < 6) begin
               m   = model({24'd0, sa[idx]}, {24'd0, sb[idx]}, sc[idx], ss[idx], 8);
               exp = {1'b1, m[32], m[33], m[7:0]};
               if (got !== exp) begin
                  n_fail++;
                  $display("FAIL stream lat%0d op%0d: got %h expected %h", lat[i], idx, got, exp);
               end
            end else if (vo[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL stream_gap lat%0d cycle%0d: got valid %b expected 0", lat[i], j, vo[i]);
            end
         end
      end
   endtask

   task automatic test_wide();
      logic [31:0] wa [6];
      logic [31:0] wb [6];
      logic        wc [6];
      logic [33:0] m;
      logic [34:0] got;
      logic [34:0] exp;
      int          idx;
      for (int i = 0; i < 6; i++) begin
         wa[i] = $urandom;
         wb[i] = $urandom;
         wc[i] = 1'($urandom_range(1, 0));
      end
      wa[0] = 32'hFFFF_FFFF; wb[0] = 32'd1; wc[0] = 1'b0;
      for (int j = 0; j < 10; j++) begin
         if (j < 6) begin
            w_valid = 1'b1; w_a = wa[j]; w_b = wb[j]; w_cin = wc[j]; w_sub = 1'(j % 2);
         end else begin
            w_valid = 1'b0;
         end
         step();
         idx = j - 3;
         got = {w_vo, w_co, w_ov, w_so};
         n_checks++;
         if (idx >= 0 && idx < 6) begin
            m   = model(wa[idx], wb[idx], wc[idx], 1'(idx % 2), 32);
            exp = {1'b1, m[32], m[33], m[31:0]};
            if (got !== exp) begin
               n_fail++;
               $display("FAIL wide op%0d: got %h expected %h", idx, got, exp);
            end
         end else if (w_vo !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_gap cycle%0d: got valid %b expected 0", j, w_vo);
         end
      end
   endtask

   task automatic test_stall();
      logic [10:0] op_a;
      logic [10:0] op_b;
      logic [10:0] got;
      op_a = {1'b1, 1'b0, 1'b0, 8'd42};
      op_b = {1'b1, 1'b1, 1'b0, 8'd60};
      flush();
      valid_in = 1'b1; a_in = 8'd20; b_in = 8'd22; sub_in = 1'b0; carry_in = 1'b0;
      step();
      a_in = 8'd90; b_in = 8'd30; sub_in = 1'b1;
      step();
      got = {vo[0], co[0], ov[0], so[0]};
      n_checks++;
      if (got !== op_a) begin
         n_fail++;
         $display("FAIL stall_pre: got %h expected %h", got, op_a);
      end
      stall_in = 1'b1; valid_in = 1'b1; a_in = 8'd1; b_in = 8'd1; sub_in = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         got = {vo[0], co[0], ov[0], so[0]};
         n_checks++;
         if (got !== op_a) begin
            n_fail++;
            $display("FAIL stall_hold_s2 cycle%0d: got %h expected %h", k, got, op_a);
         end
         got = {vo[1], co[1], ov[1], so[1]};
         n_checks++;
         if (got !== op_b) begin
            n_fail++;
            $display("FAIL stall_hold_s1 cycle%0d: got %h expected %h", k, got, op_b);
         end
      end
      stall_in = 1'b0; valid_in = 1'b0;
      for (int k = 0; k < 4; k++) begin
         step();
         got = {vo[0], co[0], ov[0], so[0]};
         n_checks++;
         if (k == 0) begin
            if (got !== op_b) begin
               n_fail++;
               $display("FAIL stall_release_s2: got %h expected %h", got, op_b);
            end
         end else if (vo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_extra_s2 cycle%0d: got valid %b expected 0", k, vo[0]);
         end
         n_checks++;
         if (vo[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_extra_s1 cycle%0d: got valid %b expected 0", k, vo[1]);
         end
         got = {vo[2], co[2], ov[2], so[2]};
         n_checks++;
         if (k == 1) begin
            if (got !== op_a) begin
               n_fail++;
               $display("FAIL stall_release_s4_a: got %h expected %h", got, op_a);
            end
         end else if (k == 2) begin
            if (got !== op_b) begin
               n_fail++;
               $display("FAIL stall_release_s4_b: got %h expected %h", got, op_b);
            end
         end else if (vo[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_extra_s4 cycle%0d: got valid %b expected 0", k, vo[2]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [10:0] op_d;
      logic [10:0] got;
      op_d = {1'b1, 1'b0, 1'b0, 8'd17};
      flush();
      valid_in = 1'b1; a_in = 8'd40; b_in = 8'd2; sub_in = 1'b0; carry_in = 1'b0;
      step();
      a_in = 8'd77; b_in = 8'd11; sub_in = 1'b1;
      step();
      rst = 1'b1; stall_in = 1'b1; a_in = 8'd99; b_in = 8'd99; sub_in = 1'b0;
      step();
      for (int i = 0; i < 4; i++) begin
         got = {vo[i], co[i], ov[i], so[i]};
         n_checks++;
         if (got !== 11'd0) begin
            n_fail++;
            $display("FAIL midreset_clear lat%0d: got %h expected %h", lat[i], got, 11'd0);
         end
      end
      rst = 1'b0; stall_in = 1'b0; valid_in = 1'b1;
      a_in = 8'd7; b_in = 8'd9; sub_in = 1'b0; carry_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int j = 0; j < 10; j++) begin
         got = {vo[0], co[0], ov[0], so[0]};
         n_checks++;
         if (j == 1) begin
            if (got !== op_d) begin
               n_fail++;
               $display("FAIL midreset_new_s2: got %h expected %h", got, op_d);
            end
         end else if (vo[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale_s2 cycle%0d: got valid %b expected 0", j, vo[0]);
         end
         got = {vo[3], co[3], ov[3], so[3]};
         n_checks++;
         if (j == 7) begin
            if (got !== op_d) begin
               n_fail++;
               $display("FAIL midreset_new_s8: got %h expected %h", got, op_d);
            end
         end else if (vo[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_stale_s8 cycle%0d: got valid %b expected 0", j, vo[3]);
         end
         step();
      end
   endtask

   initial begin
      lat = '{2, 1, 4, 8};
      test_reset();
      test_first_op();
      test_boundary();
      test_subtract();
      test_back_to_back();
      test_wide();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/add_nbit_pipe.md
Name: add_nbit_pipe

Overview:
Parametrised, pipelined N-bit adder/subtractor and the successor to the combinational add_nbit. The carry chain is split into STAGES equal slices, with a register between slices, so wide adds close timing at high clock rates. It accepts one operation per cycle using a valid flag and a global stall. It produces sum, carry and signed overflow a fixed STAGES cycles after accept.

Parameters:
N, 8, operand and sum width in bits; must be >= 1.
STAGES, 2, number of pipeline slices; 1..N; N must be divisible by STAGES; slice width W = N/STAGES.

Ports:
clk  input  1  clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
valid_in  input  1  operation present on a_in/b_in/carry_in/sub_in this cycle.
stall_in  input  1  freezes the whole pipeline while high.
sub_in  input  1  0 = add, 1 = subtract (a_in - b_in).
a_in  input  N  operand A, unsigned or two's complement.
b_in  input  N  operand B.
carry_in  input  1  carry into bit 0 in add mode; ignored in sub mode.
valid_out  output  1  sum_out/carry_out/overflow_out hold a valid result.
sum_out  output  N  result modulo 2^N.
carry_out  output  1  carry out of MSB; in sub mode 1 = no borrow (a_in >= b_in unsigned).
overflow_out  output  1  two's-complement signed overflow of the operation.

Behaviour:
- Operation: effective B = sub_in ? ~b_in : b_in; effective cin = sub_in ? 1 : carry_in; {carry_out, sum_out} = a_in + effB + cin. This is (N+1)-bit exact arithmetic.
- overflow_out = (a[N-1] == effB[N-1]) && (sum[N-1] != a[N-1]), using effective B.
- Accept: an operation is accepted on a rising edge where valid_in=1, stall_in=0 and rst=0. When valid_in=0 and stall_in=0, a bubble enters the pipeline: the valid bit is 0 and data is don't-care but deterministic.
- Pipeline: stage k (k=0..STAGES-1) adds slice bits [k*W +: W] of A and effB, plus the carry registered from stage k-1 (stage 0 uses effective cin).
  - Stage k registers its W-bit partial sum and carry.
  - Unprocessed upper operand slices and already-computed lower sum slices are delayed alongside, so each result stays aligned with its operation.
- Latency: exactly STAGES cycles. An operation accepted at edge t appears with valid_out=1 after edge t+STAGES-1, i.e. it is visible during the cycle following the STAGES-th accepting edge.
  - STAGES=1 gives one registered cycle.
  - Throughput is one operation per cycle with no gaps.
- Outputs are registered, with no combinational path from any input to any output.
- Stall: while stall_in=1, every pipeline register (data, carries, valid bits, outputs) holds its value and inputs are ignored. The same result and valid_out persist through the stall. Pipeline advance resumes on the first edge with stall_in=0.
- Reset: on an edge with rst=1, all valid bits, valid_out, sum_out, carry_out, overflow_out and internal data/carry registers are cleared to 0.
  - rst has priority over stall_in and valid_in.
  - Operations in flight are discarded and none emerges after reset.
  - The first accept is possible on the first edge with rst=0.
- Wrap-around: sum_out is modulo 2^N; the carry out of the MSB appears only on carry_out and is never truncated.
- sub_in and carry_in are sampled only at accept and travel with the operation. Mixed add/sub streams back-to-back must produce independent, correct results.

Test Plan:
- N=8, STAGES=2, after reset: valid_in pulse with a=3, b=2, add, cin=0 -> valid_out=1 exactly 2 cycles after accept; sum=5, carry=0, ovf=0. Before this, valid_out=0 and all outputs are 0.
- Boundary adds: a=255, b=255, cin=0 -> sum=254, carry=1. a=255, b=0, cin=1 -> sum=0, carry=1 (carry ripples across the slice boundary). a=127, b=1 -> sum=128, ovf=1, carry=0.
- Subtract: a=5, b=7 -> sum=254, carry=0, ovf=0. a=128, b=1 -> sum=127, carry=1, ovf=1. In sub mode with carry_in=1, carry_in is ignored and the result is unchanged.
- Streaming: 6 consecutive accepts alternating add/sub -> 6 consecutive valid_out cycles in order, each matching a reference model. Repeat for STAGES=1, 4 and 8 with N=8, and for N=32, STAGES=4 with random vectors.
- Stall: assert stall_in for 3 cycles with 2 operations in flight -> outputs and valid_out are frozen. After release, the remaining results emerge in order with none lost or duplicated; inputs presented during the stall are not accepted.
- Reset mid-operation: assert rst for 1 cycle with 2 operations in flight (and stall_in=1 simultaneously) -> all outputs are 0 on the next cycle and no stale valid_out ever appears. A new accept right after reset completes with correct latency.
